// File: rtl/wallace_accum_seq_if.sv
// Purpose: command, operand-beat and result channels of wallace_accum_seq.
// Latency: none (signal bundle only).
// Backpressure: valid/ready on each of the cmd, op and res channels.
interface wallace_accum_seq_if #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int CW = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CW-1:0]        cmd_count;
    logic [W-1:0]         cmd_init;
    logic                 op_valid;
    logic                 op_ready;
    logic [(N-1)*W-1:0]   op_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [W-1:0]         res_data;
    logic                 res_ovf;

    // Producer/consumer side
    modport master (
        output cmd_valid, cmd_count, cmd_init, op_valid, op_data, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_ovf
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_count, cmd_init, op_valid, op_data, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/wallace_accum_seq.sv
// Purpose: folds a stream of N-1-lane operand beats into one W-bit sum with a single N-input adder; optional WALLACE_ACCUM_SEQ_OVF_EN adds a sticky carry-out flag.
// Latency: one beat per cycle; result valid the cycle after the last beat (cycle after command for count 0).
// Backpressure: cmd/op/res ready-valid outputs are registered state decodes; ACCUM stalls on op_valid low, DONE holds until res_ready.
module wallace_accum_seq #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic               clk,
    input  logic               rst,
    wallace_accum_seq_if.slave bus
);
    localparam int L = N - 1;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
    localparam int G  = $clog2(N);
    localparam int AW = W + G;
`else
    localparam int AW = W;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] rem;
    logic [CW-1:0] rem_next;
    logic          cmd_ready_q;
    logic          op_ready_q;
    logic          res_valid_q;
    logic [N*AW-1:0] add_in;
    logic [AW-1:0]   add_sum;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
    logic          ovf;
`endif

    // Slot 0 carries the running total; lanes at or beyond rem are zeroed so pad lanes never count
    always_comb begin
        add_in = '0;
        add_in[0 +: AW] = AW'(acc);
        for (int j = 0; j < L; j++) begin
            if (j < int'(rem)) begin
                add_in[(j+1)*AW +: AW] = AW'(bus.op_data[j*W +: W]);
            end
        end
    end

    // Operands still owed after this beat, saturating at zero on a partial final beat
    always_comb begin
        rem_next = '0;
        if (int'(rem) > L) begin
            rem_next = rem - CW'(L);
        end
    end

    wallace_adder #(.W(AW), .N(N)) u_adder (
        .in_data (add_in),
        .sum     (add_sum)
    );

    // Control FSM; handshake outputs are registered alongside the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            rem         <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        acc         <= bus.cmd_init;
                        rem         <= bus.cmd_count;
                        cmd_ready_q <= 1'b0;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
                        ovf         <= 1'b0;
`endif
                        if (bus.cmd_count != '0) begin
                            state      <= ACCUM;
                            op_ready_q <= 1'b1;
                        end else begin
                            state       <= DONE;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.op_valid && op_ready_q) begin
                        acc <= add_sum[W-1:0];
                        rem <= rem_next;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
                        if (|add_sum[AW-1:W]) begin
                            ovf <= 1'b1;
                        end
`endif
                        if (rem_next == '0) begin
                            state       <= DONE;
                            op_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready && res_valid_q) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = acc;
`ifdef WALLACE_ACCUM_SEQ_OVF_EN
    assign bus.res_ovf   = ovf;
`else
    assign bus.res_ovf   = 1'b0;
`endif
endmodule

// Purpose: N-operand adder built from 3:2 carry-save compressors and one final carry-propagate add.
// Latency: combinational.
// Backpressure: none.
module wallace_adder #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic [N*W-1:0] in_data,
    output logic [W-1:0]   sum
);
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W-1:0] t;
    logic [W-1:0] nc;

    // Compress each extra operand into the sum/carry pair, then resolve carries once
    always_comb begin
        s  = in_data[0 +: W];
        c  = in_data[W +: W];
        t  = '0;
        nc = '0;
        for (int i = 2; i < N; i++) begin
            t  = in_data[i*W +: W];
            nc = ((s & c) | (s & t) | (c & t)) << 1;
            s  = s ^ c ^ t;
            c  = nc;
        end
        sum = s + c;
    end
endmodule
